// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline (master) and hazard_ctrl (slave).
// Carries the ID/EX/MEM hazard sources in and the register holds/flushes out.
interface hazard_ctrl_if;
  logic [4:0] rs1_addr_id;
  logic [4:0] rs2_addr_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic [4:0] rd_addr_ex;
  logic       mem_read_ex;
  logic       branch_taken_ex;
  logic       dmem_req_mem;
  logic       dmem_ready;
  logic       pc_stall;
  logic       if_id_stall;
  logic       id_ex_stall;
  logic       ex_mem_stall;
  logic       if_id_flush;
  logic       id_ex_flush;
  logic       mem_wb_flush;

  modport master (
    output rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, rd_addr_ex,
           mem_read_ex, branch_taken_ex, dmem_req_mem, dmem_ready,
    input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_flush
  );

  modport slave (
    input  rs1_addr_id, rs2_addr_id, rs1_used_id, rs2_used_id, rd_addr_ex,
           mem_read_ex, branch_taken_ex, dmem_req_mem, dmem_ready,
    output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
           if_id_flush, id_ex_flush, mem_wb_flush
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: combinational hold/flush decode (freeze > branch > load-use),
// memory-wait FSM with sticky timeout error, and saturating stall/flush statistics.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int WAIT_W      = 8,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  hazard_ctrl_if.slave     hz,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_TIMEOUT  = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_err_q, mem_err_d;
  logic [CNT_W-1:0]  stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]  flush_events_q, flush_events_d;

  logic [1:0] state_dec;
  logic       mem_busy;
  logic       load_use;
  logic       frozen;
  logic       branch_case;
  logic       pc_stall_c, if_id_stall_c, id_ex_stall_c, ex_mem_stall_c;
  logic       if_id_flush_c, id_ex_flush_c, mem_wb_flush_c;

  // The reset cycle decodes as RUN so a reset out of TIMEOUT leaves no residual freeze.
  always_comb begin
    state_dec = rst ? ST_RUN : state_q;
    mem_busy  = hz.dmem_req_mem & ~hz.dmem_ready;
    load_use  = hz.mem_read_ex & (hz.rd_addr_ex != 5'd0) &
                ((hz.rs1_used_id & (hz.rs1_addr_id == hz.rd_addr_ex)) |
                 (hz.rs2_used_id & (hz.rs2_addr_id == hz.rd_addr_ex)));
    frozen    = (state_dec == ST_TIMEOUT) | mem_busy;

    pc_stall_c     = 1'b0;
    if_id_stall_c  = 1'b0;
    id_ex_stall_c  = 1'b0;
    ex_mem_stall_c = 1'b0;
    if_id_flush_c  = 1'b0;
    id_ex_flush_c  = 1'b0;
    mem_wb_flush_c = 1'b0;
    branch_case    = 1'b0;

    if (frozen) begin
      pc_stall_c     = 1'b1;
      if_id_stall_c  = 1'b1;
      id_ex_stall_c  = 1'b1;
      ex_mem_stall_c = 1'b1;
      mem_wb_flush_c = 1'b1;
    end else if (hz.branch_taken_ex) begin
      if_id_flush_c = 1'b1;
      id_ex_flush_c = 1'b1;
      branch_case   = 1'b1;
    end else if (load_use) begin
      pc_stall_c    = 1'b1;
      if_id_stall_c = 1'b1;
      id_ex_flush_c = 1'b1;
    end
  end

  always_comb begin
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    mem_err_d      = mem_err_q;
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;

    case (state_q)
      ST_RUN: begin
        if (mem_busy) begin
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (mem_busy) begin
          if (wait_cnt_q == WAIT_LIMIT) begin
            state_d   = ST_TIMEOUT;
            mem_err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
          end
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end
      end
      ST_TIMEOUT: begin
        state_d = ST_TIMEOUT;
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (pc_stall_c && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + 1'b1;
    if (branch_case && (flush_events_q != {CNT_W{1'b1}}))
      flush_events_d = flush_events_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_RUN;
      wait_cnt_q     <= '0;
      mem_err_q      <= 1'b0;
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      state_q        <= state_d;
      wait_cnt_q     <= wait_cnt_d;
      mem_err_q      <= mem_err_d;
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.pc_stall     = pc_stall_c;
  assign hz.if_id_stall  = if_id_stall_c;
  assign hz.id_ex_stall  = id_ex_stall_c;
  assign hz.ex_mem_stall = ex_mem_stall_c;
  assign hz.if_id_flush  = if_id_flush_c;
  assign hz.id_ex_flush  = id_ex_flush_c;
  assign hz.mem_wb_flush = mem_wb_flush_c;
  assign mem_err         = mem_err_q;
  assign stall_cycles    = stall_cycles_q;
  assign flush_events    = flush_events_q;

endmodule
